// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers in-order responses
// as {pc, instr} pairs for decode, and flushes on a taken branch/jump redirect.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CSW = CW + 1;
    localparam logic [CSW-1:0] DepthC = CSW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [63:0]   mem_q [DEPTH];

    logic [CSW-1:0] credit_used;
    logic [31:0]    redirect_tgt;
    logic           req_fire;
    logic           rsp_push;
    logic           rsp_drop;
    logic           pop;
    logic           unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};

    // Queued plus in-flight fetches share one credit pool so responses can never overflow.
    assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < DepthC);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_valid            = (count_q != '0);
    assign {dec_pc, dec_instr}  = mem_q[rd_ptr_q];

    assign pop      = dec_valid && dec_ready && !redirect_valid;
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight belongs to the wrong path.
            outst_d    = outst_q - CW'(imem_rsp_valid);
            drop_d     = outst_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            count_d = count_q + CW'(rsp_push) - CW'(pop);
            outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            rsp_pc_q   <= {RESET_PC[31:2], 2'b00};
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (rsp_push) begin
                mem_q[wr_ptr_q] <= {rsp_pc_q, imem_rsp_data};
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: in-order memory model with configurable latency and a
// scoreboard of expected {pc, instr} pairs compared on every decode pop.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } dec_ent_t;

    mem_req_t    pending[$];
    dec_ent_t    exp_q[$];
    mem_req_t    m_ent;
    dec_ent_t    d_ent;
    int          cyc      = 0;
    int          lat      = 1;
    int          epoch    = 0;
    int          pops     = 0;
    int          accepts  = 0;
    logic [31:0] last_acc_addr = '0;
    int          checks   = 0;
    int          failures = 0;

    if_prefetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_pc        (dec_pc),
        .dec_instr     (dec_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr, input int ep);
        return addr ^ 32'hA5A5_0000 ^ (32'(ep) << 8);
    endfunction

    // Memory model and scoreboard: responses driven at negedge, handshakes sampled 2 ns later.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pending.delete();
            exp_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pending[0].data;
            pending.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #2;
        if (!reset) begin
            if (redirect_valid) begin
                exp_q.delete();
            end else if (dec_valid && dec_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected_pc", dec_pc, 32'hFFFF_FFFF);
                end else begin
                    d_ent = exp_q.pop_front();
                    check("pop_pc", dec_pc, d_ent.pc);
                    check("pop_instr", dec_instr, d_ent.instr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                accepts++;
                last_acc_addr = imem_req_addr;
                m_ent.addr = imem_req_addr;
                m_ent.data = mem_data(imem_req_addr, epoch);
                m_ent.due  = cyc + lat;
                pending.push_back(m_ent);
                d_ent.pc    = imem_req_addr;
                d_ent.instr = m_ent.data;
                exp_q.push_back(d_ent);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 reset = 1'b1;
        epoch++;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int a0;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);

        // Sequential fetch, 1-cycle memory, decode always ready.
        reset = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (dec_valid) break;
        end
        check("req_to_dec_latency", 32'(n), 32'd2);
        check("first_dec_pc", dec_pc, RESET_PC);
        p0 = pops;
        repeat (10) step();
        check("throughput_10", 32'(pops - p0), 32'd10);

        // Decode stalled: credits cap requests at DEPTH.
        dec_ready = 1'b0;
        do_reset();
        a0 = accepts;
        repeat (12) step();
        check("stall_accepts", 32'(accepts - a0), 32'(DEPTH));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_head_pc", dec_pc, 32'h0);
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (accepts - a0 >= 5) break;
            step();
        end
        check("resume_addr", last_acc_addr, 32'h10);

        // Redirect with two fetches in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (pending.size() == 2) break;
            step();
        end
        check("outstanding_before_redirect", 32'(pending.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (dec_valid) break;
            step();
            n++;
        end
        check("redir_to_dec_latency", 32'(n), 32'd5);
        check("redir_dec_pc", dec_pc, 32'h100);

        // Misaligned redirect target is word-aligned.
        lat = 1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        #1;
        check("align_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 20; i++) begin
            step();
            if (dec_valid) break;
        end
        check("align_dec_pc", dec_pc, 32'h100);

        // Memory back-pressure for 5 cycles at 0x8.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (imem_req_addr == 32'h8) break;
            step();
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_addr_hold", imem_req_addr, 32'h8);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        check("bp_next_addr", imem_req_addr, 32'hC);
        repeat (6) step();

        // Reset mid-operation with entries queued and fetches in flight.
        lat       = 3;
        dec_ready = 1'b0;
        do_reset();
        repeat (6) step();
        check("pre_reset_dec_valid", 32'(dec_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dec_valid", 32'(dec_valid), 32'd0);
        check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_rst_dec_pc", dec_pc, 32'd0);
        epoch++;
        step();
        step();
        reset = 1'b0;
        #1;
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, RESET_PC);
        dec_ready = 1'b1;
        p0 = pops;
        repeat (15) step();
        check("post_rst_pops_seen", 32'(pops - p0 > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
